// File: rtl/note_sequencer.sv
// note_sequencer
//   Steps through a small programmable melody table and drives the shared
//   square-wave note divider (half-period compare value + tone enable).
//   A held keyboard note overrides the divider and freezes playback; the
//   song picks up exactly where it paused once the key is released.
//
// Ports
//   clk, reset     100 MHz clock, synchronous active-high reset
//   wr_en/addr/data table write port, entry = {note[7:4], beats[3:0]}
//   start          begin playback at entry 0 (ignored while busy)
//   stop           abort playback (beats start, loop and key)
//   loop           wrap to entry 0 at end-of-song instead of finishing
//   key_valid/note live keyboard note, codes 1..8 are audible
//   half_period    divider compare value
//   tone_en        divider output audible
//   busy           sequencer not IDLE
//   done           one-cycle pulse on natural song completion
//   cur_addr       table entry being played
module note_sequencer #(
    parameter int BEAT_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 1000000,
    parameter int DEPTH       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    input  logic        key_valid,
    input  logic [3:0]  key_note,
    output logic [19:0] half_period,
    output logic        tone_en,
    output logic        busy,
    output logic        done,
    output logic [3:0]  cur_addr
);

    // One down-counter serves both PLAY and GAP, so it is sized for the
    // longest note (15 beats); 29 bits at the default beat length.
    localparam int CW_PLAY = $clog2(15 * BEAT_CYCLES + 1);
    localparam int CW_GAP  = $clog2(GAP_CYCLES + 1);
    localparam int CW_MAX  = (CW_PLAY > CW_GAP) ? CW_PLAY : CW_GAP;
    localparam int CW      = (CW_MAX > 5) ? CW_MAX : 5;

    localparam logic [CW-1:0] BEAT_W = CW'(BEAT_CYCLES);
    localparam logic [CW-1:0] GAP_W  = CW'(GAP_CYCLES);
    localparam logic [3:0]    LAST   = 4'(DEPTH - 1);

    typedef struct packed {
        logic [3:0] note;
        logic [3:0] beats;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t          state;
    logic [3:0]      addr;
    logic [3:0]      note_q;
    logic [CW-1:0]   cnt;
    logic [7:0]      tbl [DEPTH];

    entry_t          ent;
    logic            key_ok;
    logic [19:0]     key_hp;

    function automatic logic [19:0] note_hp(input logic [3:0] n);
        case (n)
            4'd1:    note_hp = 20'd191109;
            4'd2:    note_hp = 20'd170265;
            4'd3:    note_hp = 20'd151685;
            4'd4:    note_hp = 20'd143172;
            4'd5:    note_hp = 20'd127550;
            4'd6:    note_hp = 20'd113636;
            4'd7:    note_hp = 20'd101238;
            4'd8:    note_hp = 20'd95556;
            default: note_hp = 20'd0;
        endcase
    endfunction

    function automatic logic note_audible(input logic [3:0] n);
        note_audible = (n >= 4'd1) && (n <= 4'd8);
    endfunction

    // Melody table: plain register array, contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            tbl[wr_addr] <= wr_data;
    end

    assign ent      = entry_t'(tbl[addr]);
    assign key_ok   = key_valid && note_audible(key_note);
    assign key_hp   = note_hp(key_note);
    assign cur_addr = addr;

    // Every branch writes half_period/tone_en explicitly so the outputs fall
    // back to the sequencer's own value on the first cycle after a key is
    // released. In GAP and FETCH half_period keeps showing the last latched
    // note; only IDLE parks it at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr        <= '0;
            note_q      <= '0;
            cnt         <= '0;
            half_period <= '0;
            tone_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                // Kills the song but leaves a held key audible.
                state       <= IDLE;
                busy        <= 1'b0;
                half_period <= key_ok ? key_hp : 20'd0;
                tone_en     <= key_ok;
            end else if (key_ok) begin
                // Key owns the divider; state and counters stay frozen.
                half_period <= key_hp;
                tone_en     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        half_period <= '0;
                        tone_en     <= 1'b0;
                        if (start) begin
                            state  <= FETCH;
                            addr   <= '0;
                            note_q <= '0;
                            busy   <= 1'b1;
                        end
                    end

                    FETCH: begin
                        half_period <= note_hp(note_q);
                        tone_en     <= 1'b0;
                        if (ent.beats == 4'd0) begin
                            // End marker. Looping from entry 0 itself would
                            // spin forever, so an empty song always finishes.
                            if (loop && addr != 4'd0) begin
                                addr <= '0;
                            end else begin
                                state       <= IDLE;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                half_period <= '0;
                            end
                        end else begin
                            note_q      <= ent.note;
                            cnt         <= CW'(ent.beats) * BEAT_W - CW'(1);
                            state       <= PLAY;
                            half_period <= note_hp(ent.note);
                            tone_en     <= note_audible(ent.note);
                        end
                    end

                    PLAY: begin
                        half_period <= note_hp(note_q);
                        tone_en     <= note_audible(note_q);
                        if (cnt == '0) begin
                            state   <= GAP;
                            cnt     <= GAP_W - CW'(1);
                            tone_en <= 1'b0;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end

                    GAP: begin
                        half_period <= note_hp(note_q);
                        tone_en     <= 1'b0;
                        if (cnt == '0) begin
                            if (addr == LAST) begin
                                // Table exhausted without a marker.
                                if (loop) begin
                                    addr  <= '0;
                                    state <= FETCH;
                                end else begin
                                    state       <= IDLE;
                                    busy        <= 1'b0;
                                    done        <= 1'b1;
                                    half_period <= '0;
                                end
                            end else begin
                                addr  <= addr + 4'd1;
                                state <= FETCH;
                            end
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

    localparam logic [19:0] C4 = 20'd191109;
    localparam logic [19:0] A4 = 20'd113636;
    localparam logic [19:0] C5 = 20'd95556;
    localparam logic [19:0] G4 = 20'd127550;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_note = '0;
    logic [19:0] half_period;
    logic        tone_en;
    logic        busy;
    logic        done;
    logic [3:0]  cur_addr;

    note_sequencer #(
        .BEAT_CYCLES(10),
        .GAP_CYCLES (2),
        .DEPTH      (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .key_valid  (key_valid),
        .key_note   (key_note),
        .half_period(half_period),
        .tone_en    (tone_en),
        .busy       (busy),
        .done       (done),
        .cur_addr   (cur_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rep;
        logic        rst, wr;
        logic [3:0]  wa;
        logic [7:0]  wd;
        logic        st, sp, lp, kv;
        logic [3:0]  kn;
        logic [19:0] hp;
        logic        ton, bsy, dn;
        logic [3:0]  ad;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad = 0;
    bit   finished = 1'b0;

    function automatic logic [19:0] exp_hp(input logic [3:0] n);
        case (n)
            4'd1: exp_hp = 20'd191109;
            4'd2: exp_hp = 20'd170265;
            4'd3: exp_hp = 20'd151685;
            4'd4: exp_hp = 20'd143172;
            4'd5: exp_hp = 20'd127550;
            4'd6: exp_hp = 20'd113636;
            4'd7: exp_hp = 20'd101238;
            4'd8: exp_hp = 20'd95556;
            default: exp_hp = 20'd0;
        endcase
    endfunction

    function automatic logic [3:0] full_note(input int i);
        if (i == 3)      full_note = 4'd0;
        else if (i == 7) full_note = 4'd12;
        else             full_note = 4'((i % 8) + 1);
    endfunction

    task automatic S(input int n, input logic rst, input logic st, input logic sp,
                     input logic lp, input logic kv, input logic [3:0] kn,
                     input logic [19:0] hp, input logic ton, input logic bsy,
                     input logic dn, input logic [3:0] ad);
        vec_t v;
        v.rep = n; v.rst = rst; v.wr = 1'b0; v.wa = '0; v.wd = '0;
        v.st = st; v.sp = sp; v.lp = lp; v.kv = kv; v.kn = kn;
        v.hp = hp; v.ton = ton; v.bsy = bsy; v.dn = dn; v.ad = ad;
        vq.push_back(v);
    endtask

    task automatic W(input logic [3:0] a, input logic [7:0] d, input logic [3:0] ad);
        vec_t v;
        v.rep = 1; v.rst = 1'b0; v.wr = 1'b1; v.wa = a; v.wd = d;
        v.st = 1'b0; v.sp = 1'b0; v.lp = 1'b0; v.kv = 1'b0; v.kn = '0;
        v.hp = '0; v.ton = 1'b0; v.bsy = 1'b0; v.dn = 1'b0; v.ad = ad;
        vq.push_back(v);
    endtask

    task automatic basic_song();
        S(1,  0, 1, 0, 0, 0, 0, 20'd0, 0, 1, 0, 4'd0);
        S(20, 0, 0, 0, 0, 0, 0, C4,    1, 1, 0, 4'd0);
        S(2,  0, 0, 0, 0, 0, 0, C4,    0, 1, 0, 4'd0);
        S(1,  0, 0, 0, 0, 0, 0, C4,    0, 1, 0, 4'd1);
        S(10, 0, 0, 0, 0, 0, 0, A4,    1, 1, 0, 4'd1);
        S(2,  0, 0, 0, 0, 0, 0, A4,    0, 1, 0, 4'd1);
        S(1,  0, 0, 0, 0, 0, 0, A4,    0, 1, 0, 4'd2);
        S(1,  0, 0, 0, 0, 0, 0, 20'd0, 0, 0, 1, 4'd2);
        S(1,  0, 0, 0, 0, 0, 0, 20'd0, 0, 0, 0, 4'd2);
    endtask

    initial begin
        repeat (5000) @(posedge clk);
        if (!finished) begin
            bad++;
            $display("FAIL timeout: sequence did not complete within 5000 cycles");
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({half_period, tone_en, busy, done, cur_addr} !== 27'd0) begin
            bad++;
            $display("FAIL reset state: hp=%0d ton=%0b busy=%0b done=%0b addr=%0d",
                     half_period, tone_en, busy, done, cur_addr);
        end

        S(2, 1, 0, 0, 0, 0, 0, 20'd0, 0, 0, 0, 4'd0);

        W(4'd0, 8'h12, 4'd0); W(4'd1, 8'h61, 4'd0); W(4'd2, 8'h00, 4'd0);
        basic_song();

        S(1,  0, 1, 0, 1, 0, 0, 20'd0, 0, 1, 0, 4'd0);
        S(20, 0, 0, 0, 1, 0, 0, C4,    1, 1, 0, 4'd0);
        S(2,  0, 0, 0, 1, 0, 0, C4,    0, 1, 0, 4'd0);
        S(1,  0, 0, 0, 1, 0, 0, C4,    0, 1, 0, 4'd1);
        S(10, 0, 0, 0, 1, 0, 0, A4,    1, 1, 0, 4'd1);
        S(2,  0, 0, 0, 1, 0, 0, A4,    0, 1, 0, 4'd1);
        S(1,  0, 0, 0, 1, 0, 0, A4,    0, 1, 0, 4'd2);
        S(1,  0, 0, 0, 1, 0, 0, A4,    0, 1, 0, 4'd0);
        S(20, 0, 0, 0, 0, 0, 0, C4,    1, 1, 0, 4'd0);
        S(2,  0, 0, 0, 0, 0, 0, C4,    0, 1, 0, 4'd0);
        S(1,  0, 0, 0, 0, 0, 0, C4,    0, 1, 0, 4'd1);
        S(10, 0, 0, 0, 0, 0, 0, A4,    1, 1, 0, 4'd1);
        S(2,  0, 0, 0, 0, 0, 0, A4,    0, 1, 0, 4'd1);
        S(1,  0, 0, 0, 0, 0, 0, A4,    0, 1, 0, 4'd2);
        S(1,  0, 0, 0, 0, 0, 0, 20'd0, 0, 0, 1, 4'd2);

        S(1,  0, 1, 0, 0, 0, 4'd0,  20'd0, 0, 1, 0, 4'd0);
        S(5,  0, 0, 0, 0, 0, 4'd0,  C4,    1, 1, 0, 4'd0);
        S(5,  0, 0, 0, 0, 1, 4'd8,  C5,    1, 1, 0, 4'd0);
        S(15, 0, 1, 0, 0, 0, 4'd0,  C4,    1, 1, 0, 4'd0);
        S(2,  0, 0, 0, 0, 0, 4'd0,  C4,    0, 1, 0, 4'd0);
        S(1,  0, 0, 0, 0, 0, 4'd0,  C4,    0, 1, 0, 4'd1);
        S(3,  0, 0, 0, 0, 1, 4'd12, A4,    1, 1, 0, 4'd1);
        S(2,  0, 0, 0, 0, 0, 4'd0,  A4,    1, 1, 0, 4'd1);
        S(1,  0, 0, 1, 0, 0, 4'd0,  20'd0, 0, 0, 0, 4'd1);
        S(1,  0, 0, 0, 0, 0, 4'd0,  20'd0, 0, 0, 0, 4'd1);
        S(1,  0, 1, 1, 0, 0, 4'd0,  20'd0, 0, 0, 0, 4'd1);
        S(1,  0, 0, 0, 0, 1, 4'd5,  G4,    1, 0, 0, 4'd1);
        S(1,  0, 0, 1, 0, 1, 4'd5,  G4,    1, 0, 0, 4'd1);
        S(1,  0, 0, 0, 0, 0, 4'd0,  20'd0, 0, 0, 0, 4'd1);

        for (int i = 0; i < 16; i++)
            W(4'(i), {full_note(i), 4'd1}, 4'd1);
        S(1, 0, 1, 0, 0, 0, 0, 20'd0, 0, 1, 0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            logic [3:0]  n;
            logic [19:0] hp;
            logic        tn;
            n  = full_note(i);
            hp = exp_hp(n);
            tn = (n >= 4'd1) && (n <= 4'd8);
            S(10, 0, 0, 0, 0, 0, 0, hp, tn,   1, 0, 4'(i));
            S(2,  0, 0, 0, 0, 0, 0, hp, 1'b0, 1, 0, 4'(i));
            if (i < 15)
                S(1, 0, 0, 0, 0, 0, 0, hp, 1'b0, 1, 0, 4'(i + 1));
        end
        S(1, 0, 0, 0, 0, 0, 0, 20'd0, 0, 0, 1, 4'd15);

        W(4'd0, 8'h00, 4'd15);
        S(1, 0, 1, 0, 0, 0, 0, 20'd0, 0, 1, 0, 4'd0);
        S(1, 0, 0, 0, 0, 0, 0, 20'd0, 0, 0, 1, 4'd0);
        S(1, 0, 1, 0, 1, 0, 0, 20'd0, 0, 1, 0, 4'd0);
        S(1, 0, 0, 0, 1, 0, 0, 20'd0, 0, 0, 1, 4'd0);
        S(1, 0, 0, 0, 0, 0, 0, 20'd0, 0, 0, 0, 4'd0);

        W(4'd0, 8'h12, 4'd0); W(4'd1, 8'h61, 4'd0); W(4'd2, 8'h00, 4'd0);
        S(1, 0, 1, 0, 0, 0, 0, 20'd0, 0, 1, 0, 4'd0);
        S(4, 0, 0, 0, 0, 0, 0, C4,    1, 1, 0, 4'd0);
        S(1, 1, 0, 0, 0, 0, 0, 20'd0, 0, 0, 0, 4'd0);
        basic_song();

        for (int k = 0; k < vq.size(); k++) begin
            for (int r = 0; r < vq[k].rep; r++) begin
                reset     = vq[k].rst;
                wr_en     = vq[k].wr;
                wr_addr   = vq[k].wa;
                wr_data   = vq[k].wd;
                start     = vq[k].st;
                stop      = vq[k].sp;
                loop      = vq[k].lp;
                key_valid = vq[k].kv;
                key_note  = vq[k].kn;
                @(posedge clk);
                #1;
                total++;
                if ({half_period, tone_en, busy, done, cur_addr} !==
                    {vq[k].hp, vq[k].ton, vq[k].bsy, vq[k].dn, vq[k].ad}) begin
                    bad++;
                    $display("FAIL rec%0d cyc%0d: got hp=%0d ton=%0b busy=%0b done=%0b addr=%0d want hp=%0d ton=%0b busy=%0b done=%0b addr=%0d",
                             k, r, half_period, tone_en, busy, done, cur_addr,
                             vq[k].hp, vq[k].ton, vq[k].bsy, vq[k].dn, vq[k].ad);
                end
            end
        end

        finished = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Scheduler for the square-wave note divider. Holds a small programmable melody table and steps through it, driving the divider's 20-bit half-period compare value and a tone enable for a fixed number of beats per entry. Live keyboard notes share the same divider and take priority: a held key pre-empts and pauses playback. Sits between the keyboard/control logic and the single note divider that drives the speaker.

Parameters:
BEAT_CYCLES, 25000000, clk cycles per beat (250 ms at 100 MHz)
GAP_CYCLES, 1000000, silent articulation cycles after each entry (10 ms)
DEPTH, 16, melody table entries; address width 4

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high
wr_en  in  1  table write strobe
wr_addr  in  4  table write address
wr_data  in  8  entry {note[7:4], beats[3:0]}
start  in  1  begin playback from entry 0 (level sampled per cycle)
stop  in  1  abort playback
loop  in  1  restart at entry 0 on end-of-song instead of finishing
key_valid  in  1  keyboard note held
key_note  in  4  keyboard note code
half_period  out  20  divider compare value
tone_en  out  1  1 = divider output audible
busy  out  1  sequencer not IDLE
done  out  1  one-cycle pulse on natural song completion
cur_addr  out  4  entry being played

Behaviour:
- Note codes and half_period values: 0 = rest (tone_en 0, half_period 0), 1 C4 = 191109, 2 D4 = 170265, 3 E4 = 151685, 4 F4 = 143172, 5 G4 = 127550, 6 A4 = 113636, 7 B4 = 101238, 8 C5 = 95556. Codes 9–15 are treated as rest.
- Table: DEPTH x 8 register array, not reset. A write lands on the clk edge. An entry with beats == 0 is the end marker. Writes during playback are legal and take effect when that entry is next fetched.
- All outputs are registered. Reset values: half_period = 0, tone_en = 0, busy = 0, done = 0, cur_addr = 0. The state machine goes to IDLE.
- States:
  - IDLE: on start and not stop, go to FETCH with addr = 0 and busy = 1.
  - FETCH (1 cycle): read entry[addr].
    - If beats == 0: if loop is set and addr != 0, set addr = 0 and stay in FETCH. Otherwise go to IDLE and pulse done.
    - Otherwise latch note, load the beat and cycle counters, and go to PLAY.
  - PLAY: stays for exactly beats × BEAT_CYCLES cycles (rests are counted the same way). half_period and tone_en follow the latched note. Then go to GAP.
  - GAP: tone_en = 0 for GAP_CYCLES cycles; half_period holds its value.
    - If addr == DEPTH-1, treat as end-of-song using the same loop/done rule as FETCH; a loop wraps to addr 0.
    - Otherwise addr increments and the state goes to FETCH.
- cur_addr mirrors addr, registered.
- Keyboard arbitration: a key is valid when key_valid = 1 and key_note is in 1..8.
  - While valid, half_period = table[key_note] and tone_en = 1, in any state.
  - All sequencer counters freeze while a key is valid. The state is held and playback resumes the cycle after the key goes invalid, with no lost cycles.
  - An invalid key code is ignored.
- Output latency: a key or state change appears on the outputs one cycle after the causing edge.
- stop has top priority over start, loop and key:
  - Any state goes to IDLE next cycle, with no done pulse.
  - Sequencer tone_en drops; keyboard output is unaffected.
  - start and stop together leave the block in IDLE.
- start while busy is ignored.
- reset mid-song forces the IDLE reset values next cycle; table contents persist.
- Counters are sized for 15 × BEAT_CYCLES, at least 29 bits at the default.

Test Plan:
(All scenarios use BEAT_CYCLES = 10 and GAP_CYCLES = 2.)
- Basic song: write entries 0x12, 0x61, 0x00, then pulse start → tone_en = 1 with half_period 191109 for 20 cycles, 2 gap cycles, then 113636 for 10 cycles, 2 gap cycles, then a 1-cycle done pulse; busy = 0 afterwards.
- Loop: same table with loop = 1 → after entry 1, cur_addr returns to 0 and there is no done pulse. Deassert loop → done pulses at the next end marker.
- Key pre-emption: key_valid = 1 with key_note = 8 for 5 cycles mid-note → half_period 95556 for those 5 cycles, then the original note resumes for its remaining cycles; total PLAY time is 20 + 5 cycles.
- Stop/start conflict: stop during PLAY → IDLE and tone_en = 0 next cycle, no done. start and stop in the same cycle → stays IDLE.
- Edge cases:
  - Entry 0 is the end marker: start gives FETCH, then done after 2 cycles.
  - A full 16-entry table with no marker ends after addr 15.
  - Rest code 0 or 12 plays silent for its duration.
- Reset mid-PLAY → all outputs 0 next cycle; a new start replays the preserved table from entry 0.
